// File: rtl/if_stage.sv
// Fetch stage: owns the PC and the IF/ID pipeline register. A redirect takes
// effect on the next fetch, and the instruction already in IF is kept as the delay slot.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_en,
  input  logic [31:0] npc_1,
  input  logic [31:0] instr_im,
  output logic [31:0] pc_f,
  output logic        adel_f,
  output logic [31:0] pc_1,
  output logic [31:0] pc4_1,
  output logic [31:0] instr_1,
  output logic        valid_1,
  output logic        adel_1,
  output logic [31:0] fetch_cnt
);

  // The upper bound is 33 bits wide so that IM_BASE + 4*IM_WORDS cannot wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc_plus4;
  logic [31:0] pc_nxt;
  logic [31:0] pc_1_nxt;
  logic [31:0] pc4_1_nxt;
  logic [31:0] instr_1_nxt;
  logic        valid_1_nxt;
  logic        adel_1_nxt;
  logic [31:0] fetch_cnt_nxt;

  assign pc_plus4 = pc_f + 32'd4;

  // Fetch address error check, combinational on the current PC.
  always_comb begin
    adel_f = 1'b0;
    if ((pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || ({1'b0, pc_f} >= IM_LIMIT)) begin
      adel_f = 1'b1;
    end else begin
      adel_f = 1'b0;
    end
  end

  // Next-state selection for the PC, the IF/ID fields and the fetch counter.
  always_comb begin
    pc_nxt        = pc_f;
    pc_1_nxt      = pc_1;
    pc4_1_nxt     = pc4_1;
    instr_1_nxt   = instr_1;
    valid_1_nxt   = valid_1;
    adel_1_nxt    = adel_1;
    fetch_cnt_nxt = fetch_cnt;
    if (!stall) begin
      pc_nxt      = npc_en ? npc_1 : pc_plus4;
      pc_1_nxt    = pc_f;
      pc4_1_nxt   = pc_plus4;
      valid_1_nxt = 1'b1;
      adel_1_nxt  = adel_f;
      if (adel_f) begin
        instr_1_nxt = 32'h0000_0000;
      end else begin
        instr_1_nxt   = instr_im;
        fetch_cnt_nxt = fetch_cnt + 32'd1;
      end
    end else begin
      pc_nxt = pc_f;
    end
  end

  // PC and IF/ID register, with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f      <= PC_RESET;
      pc_1      <= 32'h0000_0000;
      pc4_1     <= 32'h0000_0000;
      instr_1   <= 32'h0000_0000;
      valid_1   <= 1'b0;
      adel_1    <= 1'b0;
      fetch_cnt <= 32'h0000_0000;
    end else begin
      pc_f      <= pc_nxt;
      pc_1      <= pc_1_nxt;
      pc4_1     <= pc4_1_nxt;
      instr_1   <= instr_1_nxt;
      valid_1   <= valid_1_nxt;
      adel_1    <= adel_1_nxt;
      fetch_cnt <= fetch_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: fetch, redirect with delay slot, stall,
// address errors, asynchronous reset and PC wrap-around.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        npc_en;
  logic [31:0] npc_1;
  logic [31:0] instr_im;
  logic [31:0] pc_f;
  logic        adel_f;
  logic [31:0] pc_1;
  logic [31:0] pc4_1;
  logic [31:0] instr_1;
  logic        valid_1;
  logic        adel_1;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_en(npc_en), .npc_1(npc_1),
    .instr_im(instr_im), .pc_f(pc_f), .adel_f(adel_f), .pc_1(pc_1),
    .pc4_1(pc4_1), .instr_1(instr_1), .valid_1(valid_1), .adel_1(adel_1),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_en = 1'b0; npc_1 = 32'h0; instr_im = 32'h2408_0001;
    #3;
    chk("rst_pc_f", pc_f, 32'h0000_3000);
    chk("rst_pc_1", pc_1, 32'h0);
    chk("rst_valid", {31'd0, valid_1}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Sequential fetch
    tick();
    chk("t1_pc_f_a", pc_f, 32'h0000_3004);
    chk("t1_pc_1_a", pc_1, 32'h0000_3000);
    chk("t1_pc4_1_a", pc4_1, 32'h0000_3004);
    chk("t1_valid", {31'd0, valid_1}, 32'd1);
    tick();
    chk("t1_pc_f_b", pc_f, 32'h0000_3008);
    tick();
    chk("t1_pc_f_c", pc_f, 32'h0000_300C);
    chk("t1_pc_1_c", pc_1, 32'h0000_3008);
    chk("t1_pc4_1_c", pc4_1, 32'h0000_300C);
    chk("t1_instr", instr_1, 32'h2408_0001);
    chk("t1_cnt", fetch_cnt, 32'd3);

    // Redirect keeps the delay slot
    npc_en = 1'b1; npc_1 = 32'h0000_3020;
    tick();
    chk("t2_pc_f", pc_f, 32'h0000_3020);
    chk("t2_slot_pc_1", pc_1, 32'h0000_300C);
    chk("t2_cnt", fetch_cnt, 32'd4);
    npc_en = 1'b0;
    tick();
    chk("t2_pc_f_b", pc_f, 32'h0000_3024);
    chk("t2_pc_1_b", pc_1, 32'h0000_3020);

    // Stall freezes everything and ignores the redirect
    stall = 1'b1; npc_en = 1'b1; npc_1 = 32'h0000_3100; instr_im = 32'h1234_5678;
    tick();
    tick();
    chk("t3_pc_f", pc_f, 32'h0000_3024);
    chk("t3_pc_1", pc_1, 32'h0000_3020);
    chk("t3_instr", instr_1, 32'h2408_0001);
    chk("t3_cnt", fetch_cnt, 32'd5);
    stall = 1'b0;
    tick();
    chk("t3_pc_f_rel", pc_f, 32'h0000_3100);
    chk("t3_pc_1_rel", pc_1, 32'h0000_3024);
    chk("t3_instr_rel", instr_1, 32'h1234_5678);
    chk("t3_cnt_rel", fetch_cnt, 32'd6);

    // Address errors: misaligned, upper bound, last legal word
    npc_1 = 32'h0000_3002;
    tick();
    chk("t4_pc_f_mis", pc_f, 32'h0000_3002);
    chk("t4_adel_f_mis", {31'd0, adel_f}, 32'd1);
    chk("t4_cnt_a", fetch_cnt, 32'd7);
    npc_1 = 32'h0000_4000;
    tick();
    chk("t4_adel_1", {31'd0, adel_1}, 32'd1);
    chk("t4_instr_zero", instr_1, 32'h0);
    chk("t4_pc_1_mis", pc_1, 32'h0000_3002);
    chk("t4_cnt_hold", fetch_cnt, 32'd7);
    chk("t4_adel_f_top", {31'd0, adel_f}, 32'd1);
    npc_1 = 32'h0000_3FFC;
    tick();
    chk("t4_adel_f_last", {31'd0, adel_f}, 32'd0);
    chk("t4_cnt_top", fetch_cnt, 32'd7);
    npc_en = 1'b0; instr_im = 32'hCAFE_0001;
    tick();
    chk("t4_adel_1_last", {31'd0, adel_1}, 32'd0);
    chk("t4_instr_last", instr_1, 32'hCAFE_0001);
    chk("t4_cnt_last", fetch_cnt, 32'd8);

    // Asynchronous reset between edges, during a pending redirect
    npc_en = 1'b1; npc_1 = 32'h0000_3024;
    tick();
    chk("t5_pc_f_pre", pc_f, 32'h0000_3024);
    npc_1 = 32'h0000_3100;
    #2 reset = 1'b1;
    #1;
    chk("t5_pc_f_rst", pc_f, 32'h0000_3000);
    chk("t5_valid_rst", {31'd0, valid_1}, 32'd0);
    chk("t5_cnt_rst", fetch_cnt, 32'd0);
    #1 reset = 1'b0; npc_en = 1'b0;
    tick();
    chk("t5_pc_1", pc_1, 32'h0000_3000);
    chk("t5_pc_f", pc_f, 32'h0000_3004);
    chk("t5_valid", {31'd0, valid_1}, 32'd1);

    // PC wrap-around at the top of the address space
    npc_en = 1'b1; npc_1 = 32'hFFFF_FFFC;
    tick();
    chk("t6_pc_f_top", pc_f, 32'hFFFF_FFFC);
    chk("t6_adel_f_top", {31'd0, adel_f}, 32'd1);
    npc_en = 1'b0;
    tick();
    chk("t6_pc_f_wrap", pc_f, 32'h0);
    chk("t6_pc4_1_wrap", pc4_1, 32'h0);
    chk("t6_pc_1", pc_1, 32'hFFFF_FFFC);
    chk("t6_adel_f_zero", {31'd0, adel_f}, 32'd1);
    chk("t6_cnt", fetch_cnt, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
